// File: rtl/unidade_controle_multiciclo_pkg.sv
// controle_pkg: shared states, opcodes, funct codes, ALU codes and per-state control words
package controle_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_NOR = 3'b011;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    typedef struct packed {
        logic       srca;
        logic [1:0] srcb;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [1:0] aluop;
    } ctl_t;

    // Moore control word for each state; everything not named stays 0
    function automatic ctl_t ctl_of(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.irwrite = 1'b1; c.pcen = 1'b1; c.srcb = 2'b01; end
            DECODE:   c.srcb = 2'b11;
            MEMADR:   begin c.srca = 1'b1; c.srcb = 2'b10; end
            MEMREAD:  c.iord = 1'b1;
            MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWRITE: begin c.iord = 1'b1; c.memwrite = 1'b1; end
            EXECUTE:  begin c.srca = 1'b1; c.aluop = ALUOP_FN; end
            ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BRANCH:   begin c.srca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; end
            ADDIEXEC: begin c.srca = 1'b1; c.srcb = 2'b10; end
            ADDIWB:   c.regwrite = 1'b1;
            JUMP:     begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// unidade_controle_multiciclo_if: control unit <-> datapath signal bundle
interface unidade_controle_multiciclo_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Z;
    logic [2:0] ULAControl;
    logic       ULASrcA;
    logic [1:0] ULASrcB;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       Illegal;

    modport master (
        input  Opcode, Funct, Z,
        output ULAControl, ULASrcA, ULASrcB, IorD, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, PCSrc, PCEn, Illegal
    );

    modport slave (
        output Opcode, Funct, Z,
        input  ULAControl, ULASrcA, ULASrcB, IorD, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, PCSrc, PCEn, Illegal
    );
endinterface

// File: rtl/unidade_controle_multiciclo_ula_decoder.sv
// ula_decoder: maps ALUOp and Funct to the ALU code, flagging unknown functs
module ula_decoder
    import controle_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_ula,
    output logic       o_bad
);
    logic [2:0] w_fn;
    logic       w_known;

    // funct table; unknown functs fall back to ADD so the instruction still completes
    always_comb begin
        w_known = 1'b1;
        case (i_funct)
            FN_ADD:  w_fn = ULA_ADD;
            FN_SUB:  w_fn = ULA_SUB;
            FN_AND:  w_fn = ULA_AND;
            FN_OR:   w_fn = ULA_OR;
            FN_NOR:  w_fn = ULA_NOR;
            FN_SLT:  w_fn = ULA_SLT;
            default: begin w_fn = ULA_ADD; w_known = 1'b0; end
        endcase
        o_ula = i_aluop == ALUOP_SUB ? ULA_SUB : i_aluop == ALUOP_FN ? w_fn : ULA_ADD;
        o_bad = i_aluop == ALUOP_FN && !w_known;
    end
endmodule

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multicycle Moore control FSM for the 8-bit MIPS-subset datapath
module unidade_controle_multiciclo
    import controle_pkg::*;
(
    input logic                          clk,
    input logic                          rst,
    unidade_controle_multiciclo_if.master bus
);
    state_t r_state;
    state_t w_next;
    ctl_t   r_ctl;
    logic   w_bad_op;
    logic   w_bad_fn;

    // next-state selection; Opcode is only looked at in DECODE and MEMADR
    always_comb begin
        w_next   = FETCH;
        w_bad_op = 1'b0;
        case (r_state)
            FETCH:    w_next = DECODE;
            DECODE:
                case (bus.Opcode)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXECUTE;
                    OP_BEQ:       w_next = BRANCH;
                    OP_ADDI:      w_next = ADDIEXEC;
                    OP_J:         w_next = JUMP;
                    default:      w_bad_op = 1'b1;
                endcase
            MEMADR:   w_next = bus.Opcode == OP_SW ? MEMWRITE : MEMREAD;
            MEMREAD:  w_next = MEMWB;
            EXECUTE:  w_next = ALUWB;
            ADDIEXEC: w_next = ADDIWB;
            default:  w_next = FETCH;
        endcase
    end

    // state register with control word registered alongside it, so outputs are glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_ctl   <= ctl_of(FETCH);
        end else begin
            r_state <= w_next;
            r_ctl   <= ctl_of(w_next);
        end
    end

    ula_decoder u_dec (
        .i_aluop (r_ctl.aluop),
        .i_funct (bus.Funct),
        .o_ula   (bus.ULAControl),
        .o_bad   (w_bad_fn)
    );

    assign bus.ULASrcA  = r_ctl.srca;
    assign bus.ULASrcB  = r_ctl.srcb;
    assign bus.IorD     = r_ctl.iord;
    assign bus.MemWrite = r_ctl.memwrite;
    assign bus.IRWrite  = r_ctl.irwrite;
    assign bus.RegDst   = r_ctl.regdst;
    assign bus.MemtoReg = r_ctl.memtoreg;
    assign bus.RegWrite = r_ctl.regwrite;
    assign bus.PCSrc    = r_ctl.pcsrc;
    assign bus.PCEn     = r_ctl.pcen | (r_state == BRANCH && bus.Z);
    assign bus.Illegal  = w_bad_op | w_bad_fn;
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb_unidade_controle_multiciclo: scoreboard bench stepping instructions through the control FSM
module tb_unidade_controle_multiciclo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unidade_controle_multiciclo_if bus();
    unidade_controle_multiciclo dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [15:0] q[$];

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4, S_MEMWRITE = 5;
    localparam int S_EXECUTE = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEXEC = 9, S_ADDIWB = 10, S_JUMP = 11;

    // expected outputs of one cycle, packed as {ULAControl,SrcA,SrcB,IorD,MemW,IRW,RegDst,MemtoReg,RegW,PCSrc,PCEn,Illegal}
    function automatic logic [15:0] ev(int st, logic [2:0] ula, logic ill, logic z);
        logic [2:0] u = 3'b010;
        logic sa = 0, iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, pe = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        case (st)
            S_FETCH:    begin irw = 1; pe = 1; sb = 2'b01; end
            S_DECODE:   sb = 2'b11;
            S_MEMADR:   begin sa = 1; sb = 2'b10; end
            S_MEMREAD:  iord = 1;
            S_MEMWB:    begin m2r = 1; rw = 1; end
            S_MEMWRITE: begin iord = 1; mw = 1; end
            S_EXECUTE:  begin sa = 1; u = ula; end
            S_ALUWB:    begin rd = 1; rw = 1; end
            S_BRANCH:   begin sa = 1; u = 3'b110; ps = 2'b01; pe = z; end
            S_ADDIEXEC: begin sa = 1; sb = 2'b10; end
            S_ADDIWB:   rw = 1;
            S_JUMP:     begin ps = 2'b10; pe = 1; end
            default:    u = 3'b010;
        endcase
        return {u, sa, sb, iord, mw, irw, rd, m2r, rw, ps, pe, ill};
    endfunction

    // {illegal, ALU code} for an R-type funct
    function automatic logic [3:0] fmap(logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100111: return 4'b0011;
            6'b101010: return 4'b0111;
            default:   return 4'b1010;
        endcase
    endfunction

    function automatic void push_instr(logic [5:0] op, logic [5:0] f, logic z);
        logic [3:0] m = fmap(f);
        q.push_back(ev(S_FETCH, 0, 0, 0));
        case (op)
            6'b100011: begin q.push_back(ev(S_DECODE, 0, 0, 0)); q.push_back(ev(S_MEMADR, 0, 0, 0));
                             q.push_back(ev(S_MEMREAD, 0, 0, 0)); q.push_back(ev(S_MEMWB, 0, 0, 0)); end
            6'b101011: begin q.push_back(ev(S_DECODE, 0, 0, 0)); q.push_back(ev(S_MEMADR, 0, 0, 0));
                             q.push_back(ev(S_MEMWRITE, 0, 0, 0)); end
            6'b000000: begin q.push_back(ev(S_DECODE, 0, 0, 0)); q.push_back(ev(S_EXECUTE, m[2:0], m[3], 0));
                             q.push_back(ev(S_ALUWB, 0, 0, 0)); end
            6'b000100: begin q.push_back(ev(S_DECODE, 0, 0, 0)); q.push_back(ev(S_BRANCH, 0, 0, z)); end
            6'b001000: begin q.push_back(ev(S_DECODE, 0, 0, 0)); q.push_back(ev(S_ADDIEXEC, 0, 0, 0));
                             q.push_back(ev(S_ADDIWB, 0, 0, 0)); end
            6'b000010: begin q.push_back(ev(S_DECODE, 0, 0, 0)); q.push_back(ev(S_JUMP, 0, 0, 0)); end
            default:   q.push_back(ev(S_DECODE, 0, 1, 0));
        endcase
    endfunction

    function automatic logic [15:0] obs();
        return {bus.ULAControl, bus.ULASrcA, bus.ULASrcB, bus.IorD, bus.MemWrite, bus.IRWrite,
                bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.PCSrc, bus.PCEn, bus.Illegal};
    endfunction

    task automatic test_reset();
        logic [15:0] exp;
        int n = 0;
        rst = 1; bus.Opcode = 6'b000010; bus.Funct = 0; bus.Z = 1;
        repeat (2) @(negedge clk);
        exp = ev(S_FETCH, 0, 0, 0);
        total++;
        if (obs() !== exp) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs(), exp); end
        rst = 0;
        push_instr(bus.Opcode, bus.Funct, bus.Z);
        while (q.size() > 0) begin
            exp = q.pop_front(); total++;
            if (obs() !== exp) begin bad++; $display("FAIL reset_release cyc%0d got=%h exp=%h", n, obs(), exp); end
            n++; @(negedge clk);
        end
    endtask

    task automatic test_mem_imm_jump();
        logic [15:0] exp;
        logic [5:0] ops [4] = '{6'b100011, 6'b101011, 6'b001000, 6'b000010};
        foreach (ops[k]) begin
            int n = 0;
            bus.Opcode = ops[k]; bus.Funct = 6'($urandom); bus.Z = 1'($urandom);
            push_instr(bus.Opcode, bus.Funct, bus.Z);
            while (q.size() > 0) begin
                exp = q.pop_front(); total++;
                if (obs() !== exp) begin bad++; $display("FAIL op%b cyc%0d got=%h exp=%h", ops[k], n, obs(), exp); end
                n++; @(negedge clk);
            end
        end
    endtask

    task automatic test_rtype();
        logic [15:0] exp;
        logic [5:0] fs [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000000};
        foreach (fs[k]) begin
            int n = 0;
            bus.Opcode = 6'b000000; bus.Funct = fs[k]; bus.Z = 1'($urandom);
            push_instr(bus.Opcode, bus.Funct, bus.Z);
            while (q.size() > 0) begin
                exp = q.pop_front(); total++;
                if (obs() !== exp) begin bad++; $display("FAIL rtype_fn%b cyc%0d got=%h exp=%h", fs[k], n, obs(), exp); end
                n++; @(negedge clk);
            end
        end
    endtask

    task automatic test_beq();
        logic [15:0] exp;
        for (int z = 1; z >= 0; z--) begin
            int n = 0;
            bus.Opcode = 6'b000100; bus.Funct = 6'($urandom); bus.Z = 1'(z);
            push_instr(bus.Opcode, bus.Funct, bus.Z);
            while (q.size() > 0) begin
                exp = q.pop_front(); total++;
                if (obs() !== exp) begin bad++; $display("FAIL beq_z%0d cyc%0d got=%h exp=%h", z, n, obs(), exp); end
                n++; @(negedge clk);
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] exp;
        logic [5:0] ops [3] = '{6'b111111, 6'b000001, 6'b100010};
        foreach (ops[k]) begin
            int n = 0;
            bus.Opcode = ops[k]; bus.Funct = 6'($urandom); bus.Z = 1;
            push_instr(bus.Opcode, bus.Funct, bus.Z);
            while (q.size() > 0) begin
                exp = q.pop_front(); total++;
                if (obs() !== exp) begin bad++; $display("FAIL illegal_op%b cyc%0d got=%h exp=%h", ops[k], n, obs(), exp); end
                n++; @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        int n = 0;
        bus.Opcode = 6'b100011; bus.Funct = 0; bus.Z = 1;
        q.push_back(ev(S_FETCH, 0, 0, 0)); q.push_back(ev(S_DECODE, 0, 0, 0));
        q.push_back(ev(S_MEMADR, 0, 0, 0)); q.push_back(ev(S_MEMREAD, 0, 0, 0));
        q.push_back(ev(S_FETCH, 0, 0, 0)); q.push_back(ev(S_DECODE, 0, 0, 0));
        while (q.size() > 0) begin
            exp = q.pop_front(); total++;
            if (obs() !== exp) begin bad++; $display("FAIL reset_mid cyc%0d got=%h exp=%h", n, obs(), exp); end
            rst = n == 3;
            n++; @(negedge clk);
        end
        q.push_back(ev(S_MEMADR, 0, 0, 0)); q.push_back(ev(S_MEMREAD, 0, 0, 0)); q.push_back(ev(S_MEMWB, 0, 0, 0));
        while (q.size() > 0) begin
            exp = q.pop_front(); total++;
            if (obs() !== exp) begin bad++; $display("FAIL reset_mid_rerun cyc%0d got=%h exp=%h", n, obs(), exp); end
            n++; @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        logic [5:0] ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111, 6'b000000};
        logic [5:0] fs [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b111000};
        for (int i = 0; i < 30; i++) begin
            int n = 0;
            bus.Opcode = ops[$urandom_range(0, 7)]; bus.Funct = fs[$urandom_range(0, 6)]; bus.Z = 1'($urandom);
            push_instr(bus.Opcode, bus.Funct, bus.Z);
            while (q.size() > 0) begin
                exp = q.pop_front(); total++;
                if (obs() !== exp) begin bad++; $display("FAIL b2b_i%0d op%b cyc%0d got=%h exp=%h", i, bus.Opcode, n, obs(), exp); end
                n++; @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mem_imm_jump();
        test_rtype();
        test_beq();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
